wrn_mqueue_si_arbiter: RTL and testbench
========================================

# wrn_mqueue_si_arbiter

Round-robin Wishbone arbiter that shares the single SI slave port of `wrn_mqueue_host` between `g_num_cpus` soft-CPU data-bus masters. Bus ownership is held per Wishbone cycle (CYC), so multi-access slot sequences such as claim, payload writes and commit stay atomic. The block tracks outstanding pipelined strobes, releases the bus only when they are drained, and terminates hung accesses with ERR after a timeout. It sits between the CPU crossbar outputs and `wrn_mqueue_host.si_slave_i/o`.

## Interface
Parameters:
- `g_num_cpus`, default 4: number of requesting masters, range 1..8.
- `g_timeout`, default 1024: cycles without ACK/ERR (while outstanding > 0) before forced ERR, range ≥ 2.
- `g_max_outstanding`, default 15: pipelined strobes in flight before forced stall, range 1..15.

Ports:
- `clk_i`  in  1: system clock. One clock; all logic is on its rising edge.
- `rst_n_i`  in  1: reset, synchronous, active-low.
- `cpu_slave_i`  in  t_wishbone_slave_in_array(g_num_cpus): CPU master requests.
- `cpu_slave_o`  out  t_wishbone_slave_out_array(g_num_cpus): responses to the CPUs.
- `si_master_o`  out  t_wishbone_master_out: to the mqueue SI slave.
- `si_master_i`  in  t_wishbone_master_in: from the mqueue SI slave.
- `grant_o`  out  3: index of the current owner; valid when `busy_o`=1.
- `busy_o`  out  1: bus owned or draining.
- `timeout_o`  out  1: one-cycle pulse on each forced termination.

## Operation
- States: IDLE, GRANT, DRAIN.
- **IDLE**
  - Requests are `cpu_slave_i(i).cyc`.
  - The winner is the first requester scanning `last+1, last+2, …` modulo `g_num_cpus`. `last` resets to `g_num_cpus-1`, so CPU0 wins first.
  - On the next edge: `grant`←winner, `last`←winner, state→GRANT.
- **GRANT**
  - Combinational pass-through of the owner's cyc/stb/we/sel/adr/dat to `si_master_o`.
  - ack/err/rty/dat from `si_master_i` go to the owner only.
  - Owner stall = `si_master_i.stall` OR (`outstanding` = `g_max_outstanding`).
  - `si_master_o.stb` is gated low while the forced stall is active.
- **Non-owners:** stall=1, ack=err=rty=0, dat=0.
- **Outstanding counter** (4 bits):
  - +1 on an accepted strobe (`stb & ~stall` at the SI port).
  - −1 on `ack|err|rty`.
  - Simultaneous accept and response: no change.
  - The counter never wraps.
- **Owner drops cyc**
  - `outstanding`=0: state→IDLE.
  - `outstanding`>0: state→DRAIN. Protocol violation; late responses are absorbed and not forwarded.
  - In DRAIN, `si_master_o.cyc` stays 1 and stb=0.
- **Timeout counter**
  - Cleared on any response and whenever `outstanding`=0.
  - Increments otherwise, in GRANT and DRAIN.
  - At `g_timeout`: pulse `timeout_o`. In GRANT, assert err to the owner for exactly `outstanding` cycles (one per lost strobe). In both states, zero `outstanding`.
  - During forced err the owner is stalled, and `si_master_o` cyc/stb are 0 so the slave aborts.
- **DRAIN → IDLE** when `outstanding` reaches 0, either by response or by timeout.
- **Synchronous reset** (`rst_n_i`=0 at an edge, including mid-transfer):
  - State→IDLE; all counters cleared; `last`←`g_num_cpus-1`.
  - `si_master_o`: cyc=stb=we=0, sel=0, adr=0, dat=0.
  - All `cpu_slave_o`: stall=1, ack=err=rty=0, dat=0.
  - `grant_o`=0, `busy_o`=0, `timeout_o`=0.

## Timing
- Request at edge N (cyc seen in IDLE): grant registered at N+1. The SI port sees cyc/stb from cycle N+1. The requester sees stall=1 during cycle N.
- Pass-through adds zero latency. ACK reaches the owner in the same cycle the slave asserts it.
- Release edge (owner cyc=0 and outstanding=0) puts the block in IDLE. The next grant registers one edge later, giving a minimum of 1 idle cycle between owners.
- `busy_o` = (state ≠ IDLE), registered.
- `grant_o` holds its last value while in IDLE.
- `timeout_o` asserts in the cycle after the counter reaches `g_timeout`.

## Test plan
- **Single master:** CPU1 writes 0x5 to 0x10 at cycle 100 → SI cyc/stb at 101, `grant_o`=1. The slave's ACK reaches only CPU1, and CPU0/2/3 see ack=0 throughout.
- **Simultaneous requests after reset:** CPU0 and CPU2 issue cyc in the same cycle → CPU0 granted. CPU2 is granted 2 edges after CPU0 drops cyc (1 idle cycle).
- **Fairness:** all 4 CPUs request continuously with single-access cycles → grant sequence 0,1,2,3,0,1. No CPU waits more than 3 foreign cycles.
- **Back-pressure:** `g_max_outstanding`=15 and the slave withholds ACK. A burst of 20 strobes → exactly 15 accepted, then the owner stalls and `si_master_o.stb`=0. Releasing ACKs drains the remaining 5.
- **Timeout:** `g_timeout`=16, slave never ACKs, 3 strobes accepted → `timeout_o` pulse, 3 single-cycle ERRs to the owner, outstanding=0. When the owner drops cyc the block goes to IDLE, and the next requester is granted.
- **Reset mid-burst:** `rst_n_i`=0 for 1 cycle with outstanding=5 → all outputs at reset values at the next edge. A fresh request from CPU3 then wins, since the pointer restarts and CPU0 is first only if it is also requesting.

Source files
------------

// File: rtl/wrn_mqueue_si_arbiter.sv
// wrn_mqueue_si_arbiter: round-robin Wishbone arbiter sharing the mqueue SI slave port between CPU masters.
// Ports: clk_i/rst_n_i clock and sync active-low reset; cpu_slave_i/o per-CPU Wishbone slave ports;
// si_master_o/i Wishbone master towards the SI slave; grant_o owner index; busy_o owned or draining;
// timeout_o one-cycle pulse per forced termination.
package wrn_wishbone_pkg;
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } t_wishbone_master_out;
    typedef t_wishbone_master_out t_wishbone_slave_in;
    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic [31:0] dat;
    } t_wishbone_master_in;
    typedef t_wishbone_master_in t_wishbone_slave_out;
endpackage

module wrn_mqueue_si_arbiter
    import wrn_wishbone_pkg::*;
#(
    parameter int g_num_cpus        = 4,
    parameter int g_timeout         = 1024,
    parameter int g_max_outstanding = 15
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  t_wishbone_slave_in  [g_num_cpus-1:0]  cpu_slave_i,
    output t_wishbone_slave_out [g_num_cpus-1:0]  cpu_slave_o,
    output t_wishbone_master_out                  si_master_o,
    input  t_wishbone_master_in                   si_master_i,
    output logic [2:0]                            grant_o,
    output logic                                  busy_o,
    output logic                                  timeout_o
);
    localparam int TW = $clog2(g_timeout + 1);
    localparam logic [2:0] LAST_RST = 3'(g_num_cpus - 1);
    localparam logic [3:0] MAX_OUT = 4'(g_max_outstanding);
    localparam logic [TW-1:0] TMO = TW'(g_timeout);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} t_state;

    t_state state, state_nxt;
    logic [2:0] grant, last, winner;
    logic [7:0] req;
    logic [3:0] s, outstanding, out_nxt, err_cnt, err_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic found, forced, ferr, acc, rsp, fire;
    t_wishbone_slave_in own;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        req = '0;
        for (int i = 0; i < g_num_cpus; i++) req[i] = cpu_slave_i[i].cyc;
        found = 1'b0;
        winner = last;
        s = '0;
        for (int k = 1; k <= g_num_cpus; k++) begin
            s = {1'b0, last} + 4'(k);
            if (s >= 4'(g_num_cpus)) s = s - 4'(g_num_cpus);
            if (!found && req[s[2:0]]) begin
                found = 1'b1;
                winner = s[2:0];
            end
        end
    end

    always_comb begin
        own = '0;
        for (int i = 0; i < g_num_cpus; i++) if (grant == 3'(i)) own = cpu_slave_i[i];
    end

    // ferr marks the cycles in which lost strobes are answered with a forced err.
    assign forced = outstanding == MAX_OUT;
    assign ferr   = err_cnt != '0;

    always_comb begin
        si_master_o = '0;
        if (state == GRANT) begin
            si_master_o     = own;
            si_master_o.cyc = own.cyc & ~ferr;
            si_master_o.stb = own.cyc & own.stb & ~ferr & ~forced;
        end else if (state == DRAIN) begin
            si_master_o.cyc = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < g_num_cpus; i++) begin
            cpu_slave_o[i]       = '0;
            cpu_slave_o[i].stall = 1'b1;
            if (state == GRANT && grant == 3'(i)) begin
                cpu_slave_o[i].stall = si_master_i.stall | forced | ferr;
                cpu_slave_o[i].ack   = si_master_i.ack & ~ferr;
                cpu_slave_o[i].err   = si_master_i.err | ferr;
                cpu_slave_o[i].rty   = si_master_i.rty & ~ferr;
                cpu_slave_o[i].dat   = si_master_i.dat;
            end
        end
    end

    assign acc  = si_master_o.stb & ~si_master_i.stall;
    assign rsp  = state != IDLE && (si_master_i.ack | si_master_i.err | si_master_i.rty) && outstanding != '0;
    assign fire = state != IDLE && tcnt == TMO;

    always_comb begin
        out_nxt  = fire ? '0 : outstanding + {3'b0, acc} - {3'b0, rsp};
        tcnt_nxt = (state == IDLE || fire || rsp || outstanding == '0) ? '0 : tcnt + TW'(1);
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (!own.cyc) state_nxt = (out_nxt == '0) ? IDLE : DRAIN;
            DRAIN:   if (out_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        err_nxt = (state_nxt != GRANT) ? '0 :
                  (fire && state == GRANT) ? outstanding :
                  ferr ? err_cnt - 4'd1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            grant       <= '0;
            last        <= LAST_RST;
            outstanding <= '0;
            tcnt        <= '0;
            err_cnt     <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            tcnt        <= tcnt_nxt;
            err_cnt     <= err_nxt;
            timeout_o   <= fire;
            if (state == IDLE && found) begin
                grant <= winner;
                last  <= winner;
            end
        end
    end

    assign grant_o = grant;
    assign busy_o  = state != IDLE;
endmodule

// File: tb/tb_wrn_mqueue_si_arbiter.sv
// tb_wrn_mqueue_si_arbiter: directed self-checking bench for the SI round-robin arbiter.
module tb_wrn_mqueue_si_arbiter;
    import wrn_wishbone_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    t_wishbone_slave_in  [3:0] cpu_i;
    t_wishbone_slave_out [3:0] cpu_o;
    t_wishbone_master_out si_o;
    t_wishbone_master_in  si_i;
    logic [2:0] grant_o;
    logic busy_o, timeout_o;
    t_wishbone_slave_out exp_idle;
    int checks = 0;
    int passed = 0;

    wrn_mqueue_si_arbiter #(.g_num_cpus(4), .g_timeout(16), .g_max_outstanding(15)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_slave_i(cpu_i), .cpu_slave_o(cpu_o),
        .si_master_o(si_o), .si_master_i(si_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        cpu_i = '0;
        si_i = '0;
        rst_n_i = 1'b0;
        tick;
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset;
        cpu_i = '0;
        si_i = '0;
        rst_n_i = 1'b0;
        tick;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 3'd0 || timeout_o !== 1'b0)
            $display("FAIL reset_status: busy=%b grant=%0d tmo=%b, required 0 0 0", busy_o, grant_o, timeout_o);
        else passed++;
        checks++;
        if (si_o !== '0) $display("FAIL reset_si: si_o=%h, required 0", si_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cpu_o[i] !== exp_idle) $display("FAIL reset_cpu%0d: got %h, required %h", i, cpu_o[i], exp_idle);
            else passed++;
        end
        rst_n_i = 1'b1;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        cpu_i[1].cyc = 1'b1;
        cpu_i[1].stb = 1'b1;
        cpu_i[1].we  = 1'b1;
        cpu_i[1].adr = 32'h10;
        cpu_i[1].dat = 32'h5;
        cpu_i[1].sel = 4'hf;
        #1;
        checks++;
        if (cpu_o[1].stall !== 1'b1 || si_o.cyc !== 1'b0)
            $display("FAIL single_req_cycle: stall=%b si_cyc=%b, required 1 0", cpu_o[1].stall, si_o.cyc);
        else passed++;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd1 || busy_o !== 1'b1)
            $display("FAIL single_grant: grant=%0d busy=%b, required 1 1", grant_o, busy_o);
        else passed++;
        checks++;
        if (si_o.cyc !== 1'b1 || si_o.stb !== 1'b1 || si_o.we !== 1'b1 || si_o.adr !== 32'h10 || si_o.dat !== 32'h5 || cpu_o[1].stall !== 1'b0)
            $display("FAIL single_pass: cyc=%b stb=%b we=%b adr=%h dat=%h stall=%b, required 1 1 1 10 5 0",
                     si_o.cyc, si_o.stb, si_o.we, si_o.adr, si_o.dat, cpu_o[1].stall);
        else passed++;
        tick;
        cpu_i[1].stb = 1'b0;
        si_i.ack = 1'b1;
        #1;
        checks++;
        if (cpu_o[1].ack !== 1'b1 || cpu_o[0].ack !== 1'b0 || cpu_o[2].ack !== 1'b0 || cpu_o[3].ack !== 1'b0)
            $display("FAIL single_ack_route: acks(0..3)=%b%b%b%b, required 0100",
                     cpu_o[0].ack, cpu_o[1].ack, cpu_o[2].ack, cpu_o[3].ack);
        else passed++;
        tick;
        si_i.ack = 1'b0;
        cpu_i[1] = '0;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 3'd1 || si_o.cyc !== 1'b0)
            $display("FAIL single_release: busy=%b grant=%0d si_cyc=%b, required 0 1 0", busy_o, grant_o, si_o.cyc);
        else passed++;
    endtask

    task automatic test_simultaneous;
        do_reset;
        cpu_i[0].cyc = 1'b1;
        cpu_i[2].cyc = 1'b1;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd0 || busy_o !== 1'b1 || cpu_o[2].stall !== 1'b1)
            $display("FAIL simul_first: grant=%0d busy=%b stall2=%b, required 0 1 1", grant_o, busy_o, cpu_o[2].stall);
        else passed++;
        cpu_i[0].cyc = 1'b0;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL simul_idle_gap: busy=%b, required 0", busy_o);
        else passed++;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd2 || busy_o !== 1'b1)
            $display("FAIL simul_second: grant=%0d busy=%b, required 2 1", grant_o, busy_o);
        else passed++;
        cpu_i = '0;
        tick;
        tick;
    endtask

    task automatic test_fairness;
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        int e;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            cpu_i[i].cyc = 1'b1;
            cpu_i[i].stb = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            e = exp_seq[k];
            tick;
            #1;
            checks++;
            if (grant_o !== 3'(e) || busy_o !== 1'b1)
                $display("FAIL fair_grant%0d: grant=%0d busy=%b, required %0d 1", k, grant_o, busy_o, e);
            else passed++;
            tick;
            cpu_i[e].stb = 1'b0;
            si_i.ack = 1'b1;
            tick;
            si_i.ack = 1'b0;
            cpu_i[e].cyc = 1'b0;
            tick;
            cpu_i[e].cyc = 1'b1;
            cpu_i[e].stb = 1'b1;
        end
        cpu_i = '0;
        tick;
        tick;
    endtask

    task automatic test_backpressure;
        int acc = 0;
        int acks = 0;
        int tmo = 0;
        do_reset;
        cpu_i[0].cyc = 1'b1;
        tick;
        cpu_i[0].stb = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (!cpu_o[0].stall) acc++;
            if (timeout_o) tmo++;
            tick;
        end
        #1;
        checks++;
        if (acc != 15) $display("FAIL bp_accepted: accepted=%0d, required 15", acc);
        else passed++;
        checks++;
        if (cpu_o[0].stall !== 1'b1 || si_o.stb !== 1'b0 || si_o.cyc !== 1'b1)
            $display("FAIL bp_stall: stall=%b si_stb=%b si_cyc=%b, required 1 0 1", cpu_o[0].stall, si_o.stb, si_o.cyc);
        else passed++;
        for (int c = 0; c < 25; c++) begin
            cpu_i[0].stb = acc < 20;
            si_i.ack = acks < 20;
            #1;
            if (cpu_i[0].stb && !cpu_o[0].stall) acc++;
            if (cpu_o[0].ack) acks++;
            if (timeout_o) tmo++;
            tick;
        end
        cpu_i[0] = '0;
        si_i.ack = 1'b0;
        checks++;
        if (acc != 20 || acks != 20 || tmo != 0)
            $display("FAIL bp_drain: accepted=%0d acks=%0d timeouts=%0d, required 20 20 0", acc, acks, tmo);
        else passed++;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL bp_release: busy=%b, required 0", busy_o);
        else passed++;
    endtask

    task automatic test_timeout;
        int tmo = 0;
        int errs = 0;
        int bad = 0;
        int first = -1;
        do_reset;
        cpu_i[1].cyc = 1'b1;
        cpu_i[1].stb = 1'b1;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd1) $display("FAIL tmo_grant: grant=%0d, required 1", grant_o);
        else passed++;
        tick;
        tick;
        tick;
        cpu_i[1].stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (timeout_o) begin
                tmo++;
                if (first < 0) first = i;
                if (!cpu_o[1].err) bad++;
            end
            if (cpu_o[1].err) begin
                errs++;
                if (si_o.cyc || si_o.stb || !cpu_o[1].stall) bad++;
            end
            tick;
        end
        checks++;
        if (tmo != 1 || first != 15)
            $display("FAIL tmo_pulse: pulses=%0d first_at=%0d, required 1 15", tmo, first);
        else passed++;
        checks++;
        if (errs != 3) $display("FAIL tmo_errs: errs=%0d, required 3", errs);
        else passed++;
        checks++;
        if (bad != 0) $display("FAIL tmo_abort: bad_cycles=%0d, required 0", bad);
        else passed++;
        #1;
        checks++;
        if (si_o.cyc !== 1'b1 || cpu_o[1].stall !== 1'b0)
            $display("FAIL tmo_after: si_cyc=%b stall=%b, required 1 0", si_o.cyc, cpu_o[1].stall);
        else passed++;
        cpu_i[1].cyc = 1'b0;
        cpu_i[2].cyc = 1'b1;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL tmo_idle: busy=%b, required 0", busy_o);
        else passed++;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd2 || busy_o !== 1'b1)
            $display("FAIL tmo_next: grant=%0d busy=%b, required 2 1", grant_o, busy_o);
        else passed++;
        cpu_i = '0;
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        cpu_i[1].cyc = 1'b1;
        cpu_i[1].stb = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) tick;
        rst_n_i = 1'b0;
        cpu_i[1] = '0;
        cpu_i[3].cyc = 1'b1;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0 || grant_o !== 3'd0 || timeout_o !== 1'b0 || si_o !== '0)
            $display("FAIL rstmid_status: busy=%b grant=%0d tmo=%b si=%h, required 0 0 0 0", busy_o, grant_o, timeout_o, si_o);
        else passed++;
        checks++;
        if (cpu_o[0] !== exp_idle || cpu_o[1] !== exp_idle || cpu_o[2] !== exp_idle || cpu_o[3] !== exp_idle)
            $display("FAIL rstmid_cpu: cpu1=%h, required %h", cpu_o[1], exp_idle);
        else passed++;
        rst_n_i = 1'b1;
        tick;
        #1;
        checks++;
        if (grant_o !== 3'd3 || busy_o !== 1'b1)
            $display("FAIL rstmid_grant: grant=%0d busy=%b, required 3 1", grant_o, busy_o);
        else passed++;
        cpu_i[3].cyc = 1'b0;
        tick;
        #1;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL rstmid_cleared: busy=%b, required 0", busy_o);
        else passed++;
    endtask

    initial begin
        exp_idle = '0;
        exp_idle.stall = 1'b1;
        cpu_i = '0;
        si_i = '0;
        test_reset;
        test_single;
        test_simultaneous;
        test_fairness;
        test_backpressure;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
